// File: rtl/rr_dff_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit register (q/nq) among N_REQ
// requesters. The owner streams its data slice into q, one load per falling
// edge, and is limited to MAX_BURST consecutive loads while others wait.
module rr_dff_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int OWN_W     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] d_bus,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       nq,
    output logic                   busy,
    output logic [OWN_W-1:0]       owner
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               busy_q, busy_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [OWN_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic               win_found;
    logic [OWN_W-1:0]   win_idx;
    logic [OWN_W-1:0]   cand;
    logic [OWN_W-1:0]   owner_next;
    logic               others_pending;
    logic [CNT_W-1:0]   burst_inc;
    logic [WIDTH-1:0]   owner_slice;

    // Round-robin search: first asserted request starting at ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = OWN_W'((int'(ptr_q) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Helpers for the granted owner: successor index, competitors, data slice.
    always_comb begin
        owner_next     = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        others_pending = (req & ~(N_REQ'(1) << owner_q)) != '0;
        burst_inc      = burst_cnt_q + 1'b1;
        owner_slice    = d_bus[int'(owner_q)*WIDTH +: WIDTH];
    end

    // Next-state logic: arbitrate in IDLE, load/limit/release in GRANT.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        q_d         = q_q;
        busy_d      = busy_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d       = N_REQ'(1) << win_idx;
                    owner_d     = win_idx;
                    busy_d      = 1'b1;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (req[owner_q]) begin
                    q_d = owner_slice;
                    if (burst_inc == CNT_W'(MAX_BURST)) begin
                        if (others_pending) begin
                            // Burst exhausted with competitors waiting: hand over.
                            gnt_d       = '0;
                            busy_d      = 1'b0;
                            ptr_d       = owner_next;
                            burst_cnt_d = '0;
                            state_d     = IDLE;
                        end else begin
                            // Nobody else wants it: restart the burst, no gap.
                            burst_cnt_d = '0;
                        end
                    end else begin
                        burst_cnt_d = burst_inc;
                    end
                end else begin
                    gnt_d       = '0;
                    busy_d      = 1'b0;
                    ptr_d       = owner_next;
                    burst_cnt_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register, updated on the falling edge with synchronous reset.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            q_q         <= '0;
            busy_q      <= 1'b0;
            owner_q     <= '0;
            ptr_q       <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            q_q         <= q_d;
            busy_q      <= busy_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign q     = q_q;
    assign nq    = ~q_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_rr_dff_arbiter.sv
// Directed bench for rr_dff_arbiter: reset, single requester, contention,
// fairness, lone streamer and reset mid-burst.
module tb_rr_dff_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  d [4];
    logic [31:0] d_bus;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [7:0]  nq;
    logic        busy;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_errors = 0;

    assign d_bus = {d[3], d[2], d[1], d[0]};

    rr_dff_arbiter #(
        .N_REQ(4), .WIDTH(8), .MAX_BURST(4), .OWN_W(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .d_bus(d_bus),
        .gnt(gnt), .q(q), .nq(nq), .busy(busy), .owner(owner)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one active (falling) edge; outputs are settled afterwards.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int edges);
        rst = 1'b1;
        repeat (edges) tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_q"},     32'(q),     32'h00);
        check({tag, "_nq"},    32'(nq),    32'hFF);
        check({tag, "_gnt"},   32'(gnt),   32'h0);
        check({tag, "_busy"},  32'(busy),  32'h0);
        check({tag, "_owner"}, 32'(owner), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        for (int i = 0; i < 4; i++) d[i] = 8'h00;

        // 1: reset with all requests high
        req = 4'b1111;
        do_reset(2);
        check_reset_vals("rst");

        // 2: single requester
        do_reset(1);
        req  = 4'b0001;
        d[0] = 8'hA5;
        tick();
        check("single_gnt",  32'(gnt),  32'h1);
        check("single_busy", 32'(busy), 32'h1);
        check("single_q0",   32'(q),    32'h00);
        tick();
        check("single_q",    32'(q),    32'hA5);
        check("single_nq",   32'(nq),   32'h5A);
        req = 4'b0000;
        tick();
        check("single_rel_gnt",  32'(gnt),  32'h0);
        check("single_rel_busy", 32'(busy), 32'h0);
        check("single_hold_q",   32'(q),    32'hA5);

        // 3: contention between 0 and 2, burst limit of 4
        do_reset(1);
        req  = 4'b0101;
        d[0] = 8'h10;
        d[2] = 8'hC3;
        tick();
        check("cont_gnt0", 32'(gnt), 32'h1);
        for (int k = 0; k < 4; k++) begin
            d[0] = 8'h20 + 8'(k);
            tick();
            check($sformatf("cont_q%0d", k),   32'(q),   32'(8'h20 + 8'(k)));
            check($sformatf("cont_gnt%0d", k), 32'(gnt), (k < 3) ? 32'h1 : 32'h0);
        end
        tick();
        check("cont_gnt2",   32'(gnt),   32'h4);
        check("cont_owner2", 32'(owner), 32'h2);
        check("cont_q_hold", 32'(q),     32'h23);
        tick();
        check("cont_q2", 32'(q), 32'hC3);

        // 4: fairness, each owner drops after one load
        do_reset(1);
        for (int i = 0; i < 4; i++) d[i] = 8'h40 + 8'(i);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check($sformatf("fair_gnt%0d", g),   32'(gnt),   32'(4'b0001 << (g % 4)));
            check($sformatf("fair_owner%0d", g), 32'(owner), 32'(g % 4));
            tick();
            check($sformatf("fair_q%0d", g), 32'(q), 32'(8'h40 + 8'(g % 4)));
            req[g % 4] = 1'b0;
            tick();
            check($sformatf("fair_idle%0d", g), 32'(gnt), 32'h0);
            req = 4'b1111;
        end

        // 5: lone streamer across burst boundaries
        do_reset(1);
        req = 4'b0010;
        tick();
        check("lone_gnt_start", 32'(gnt), 32'h2);
        for (int k = 0; k < 10; k++) begin
            d[1] = 8'h30 + 8'(k);
            tick();
            check($sformatf("lone_gnt%0d", k),  32'(gnt),  32'h2);
            check($sformatf("lone_busy%0d", k), 32'(busy), 32'h1);
            check($sformatf("lone_q%0d", k),    32'(q),    32'(8'h30 + 8'(k)));
        end

        // 6: reset mid-burst
        do_reset(1);
        req  = 4'b0100;
        d[2] = 8'h77;
        tick();
        check("mid_owner", 32'(owner), 32'h2);
        tick();
        tick();
        check("mid_q", 32'(q), 32'h77);
        req = 4'b1111;
        do_reset(1);
        check_reset_vals("mid_rst");
        tick();
        check("mid_regrant", 32'(gnt),   32'h1);
        check("mid_owner0",  32'(owner), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
